npr_arbiter: RTL and testbench

- Shares one Unibus NPR (DMA) master port among NREQ device controllers: TM11 tape, RK/RL disks, and others.
- Each requester posts single-word DATI/DATO(B) transfers.
- The arbiter picks requesters round-robin, acquires the bus, runs the master cycle with deskew/timeout and returns the data or NXM.
- Sits between the device blocks and the Unibus pad logic in the Zynq fabric.

---
 rtl/npr_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_npr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npr_arbiter.sv
// npr_arbiter: round-robin sharing of one Unibus NPR master port among NREQ requesters.
// Define NPR_ARBITER_BURST_EN to allow up to 4 transfers per bus tenure.
module npr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*18-1:0]   req_addr,
    input  logic [NREQ*2-1:0]    req_ctl,
    input  logic [NREQ*16-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [15:0]          rdata,
    output logic                 nxm,
    input  logic                 init_in_h,
    output logic                 npr_out_h,
    input  logic                 npg_in_h,
    output logic                 sack_out_h,
    input  logic                 bbsy_in_h,
    output logic                 bbsy_out_h,
    output logic [17:0]          a_out_h,
    output logic [1:0]           c_out_h,
    output logic [15:0]          d_out_h,
    output logic                 msyn_out_h,
    input  logic                 ssyn_in_h,
    input  logic [15:0]          d_in_h
);

    localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TIMEOUT > DESKEW) ? TIMEOUT : DESKEW;
    localparam int CW   = $clog2(CMAX + 2);

`ifdef NPR_ARBITER_BURST_EN
    localparam logic [1:0] BURST_LAST = 2'd3;
`else
    localparam logic [1:0] BURST_LAST = 2'd0;
`endif

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQBUS   = 3'd1;
    localparam logic [2:0] ST_WAITBUS  = 3'd2;
    localparam logic [2:0] ST_SETUP    = 3'd3;
    localparam logic [2:0] ST_WAITSSYN = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;
    localparam logic [2:0] ST_ACK      = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [17:0]     addr_q, addr_d;
    logic [1:0]      ctl_q, ctl_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      burst_q, burst_d;
    logic            npr_q, npr_d;
    logic            sack_q, sack_d;
    logic            bbsy_q, bbsy_d;
    logic [17:0]     a_q, a_d;
    logic [1:0]      c_q, c_d;
    logic [15:0]     d_q, d_d;
    logic            msyn_q, msyn_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            nxm_q, nxm_d;

    logic [SW-1:0]   pick_s;
    logic [SW-1:0]   op_idx_s;
    logic [17:0]     op_addr_s;
    logic [1:0]      op_ctl_s;
    logic [15:0]     op_wdata_s;

    // First set request at or above p, wrapping; the just-served index sits lowest.
    function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [SW-1:0] p);
        logic [SW-1:0] idx;
        logic          found;
        int            j;
        idx   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(p) + i) % NREQ;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = SW'(j);
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    function automatic logic [SW-1:0] ptr_after(input logic [SW-1:0] s);
        return SW'((int'(s) + 1) % NREQ);
    endfunction

    assign pick_s     = rr_pick(req, ptr_q);
    assign op_idx_s   = (state_q == ST_IDLE) ? pick_s : sel_q;
    assign op_addr_s  = req_addr[int'(op_idx_s)*18 +: 18];
    assign op_ctl_s   = req_ctl[int'(op_idx_s)*2 +: 2];
    assign op_wdata_s = req_wdata[int'(op_idx_s)*16 +: 16];

    // Next-state and bus-signal sequencing.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        ctl_d   = ctl_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        npr_d   = npr_q;
        sack_d  = sack_q;
        bbsy_d  = bbsy_q;
        a_d     = a_q;
        c_d     = c_q;
        d_d     = d_q;
        msyn_d  = msyn_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        nxm_d   = nxm_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    sel_d   = pick_s;
                    ptr_d   = ptr_after(pick_s);
                    addr_d  = op_addr_s;
                    ctl_d   = op_ctl_s;
                    wdata_d = op_wdata_s;
                    npr_d   = 1'b1;
                    state_d = ST_REQBUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQBUS: begin
                if (npg_in_h) begin
                    sack_d  = 1'b1;
                    state_d = ST_WAITBUS;
                end else begin
                    state_d = ST_REQBUS;
                end
            end
            ST_WAITBUS: begin
                if (!npg_in_h && !bbsy_in_h && !ssyn_in_h) begin
                    bbsy_d  = 1'b1;
                    npr_d   = 1'b0;
                    a_d     = addr_q;
                    c_d     = ctl_q;
                    d_d     = ctl_q[1] ? wdata_q : 16'h0000;
                    cnt_d   = CW'(DESKEW);
                    burst_d = 2'd0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_WAITBUS;
                end
            end
            ST_SETUP: begin
                // Firing on the last count keeps MSYN exactly DESKEW cycles behind the address.
                if (cnt_q <= CW'(1)) begin
                    msyn_d  = 1'b1;
                    sack_d  = 1'b0;
                    cnt_d   = CW'(TIMEOUT);
                    state_d = ST_WAITSSYN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAITSSYN: begin
                if (ssyn_in_h) begin
                    rdata_d = ctl_q[1] ? 16'h0000 : d_in_h;
                    nxm_d   = 1'b0;
                    msyn_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else if (cnt_q <= CW'(1)) begin
                    rdata_d = 16'h0000;
                    nxm_d   = 1'b1;
                    msyn_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RELEASE: begin
                if (nxm_q || !ssyn_in_h) begin
                    a_d          = 18'h00000;
                    c_d          = 2'b00;
                    d_d          = 16'h0000;
                    ack_d[sel_q] = 1'b1;
                    bbsy_d       = (burst_q != BURST_LAST);
                    state_d      = ST_ACK;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_ACK: begin
                // bbsy still held here only while a burst may continue.
                if (bbsy_q && req[sel_q]) begin
                    addr_d  = op_addr_s;
                    ctl_d   = op_ctl_s;
                    wdata_d = op_wdata_s;
                    a_d     = op_addr_s;
                    c_d     = op_ctl_s;
                    d_d     = op_ctl_s[1] ? op_wdata_s : 16'h0000;
                    cnt_d   = CW'(DESKEW);
                    burst_d = burst_q + 2'd1;
                    state_d = ST_SETUP;
                end else begin
                    bbsy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; RESET and Unibus INIT both abort to IDLE.
    always_ff @(posedge CLOCK) begin
        if (RESET || init_in_h) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            addr_q  <= 18'h00000;
            ctl_q   <= 2'b00;
            wdata_q <= 16'h0000;
            cnt_q   <= '0;
            burst_q <= 2'd0;
            npr_q   <= 1'b0;
            sack_q  <= 1'b0;
            bbsy_q  <= 1'b0;
            a_q     <= 18'h00000;
            c_q     <= 2'b00;
            d_q     <= 16'h0000;
            msyn_q  <= 1'b0;
            ack_q   <= '0;
            rdata_q <= 16'h0000;
            nxm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            ctl_q   <= ctl_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            npr_q   <= npr_d;
            sack_q  <= sack_d;
            bbsy_q  <= bbsy_d;
            a_q     <= a_d;
            c_q     <= c_d;
            d_q     <= d_d;
            msyn_q  <= msyn_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            nxm_q   <= nxm_d;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign nxm        = nxm_q;
    assign npr_out_h  = npr_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;
    assign a_out_h    = a_q;
    assign c_out_h    = c_q;
    assign d_out_h    = d_q;
    assign msyn_out_h = msyn_q;

endmodule

// File: tb/tb_npr_arbiter.sv
// tb_npr_arbiter: directed vectors plus multi-cycle sequences for npr_arbiter,
// with simple grant and slave responders on the Unibus side.
module tb_npr_arbiter;

    localparam int NREQ    = 4;
    localparam int DESKEW  = 15;
    localparam int TIMEOUT = 1000;

    logic              CLOCK;
    logic              RESET;
    logic [NREQ-1:0]   req;
    logic [NREQ*18-1:0] req_addr;
    logic [NREQ*2-1:0] req_ctl;
    logic [NREQ*16-1:0] req_wdata;
    logic [NREQ-1:0]   ack;
    logic [15:0]       rdata;
    logic              nxm;
    logic              init_in_h;
    logic              npr_out_h;
    logic              npg_in_h;
    logic              sack_out_h;
    logic              bbsy_in_h;
    logic              bbsy_out_h;
    logic [17:0]       a_out_h;
    logic [1:0]        c_out_h;
    logic [15:0]       d_out_h;
    logic              msyn_out_h;
    logic              ssyn_in_h;
    logic [15:0]       d_in_h;

    npr_arbiter #(.NREQ(NREQ), .DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .req(req), .req_addr(req_addr), .req_ctl(req_ctl),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .nxm(nxm), .init_in_h(init_in_h),
        .npr_out_h(npr_out_h), .npg_in_h(npg_in_h), .sack_out_h(sack_out_h),
        .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h),
        .d_out_h(d_out_h), .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    int          grant_delay = 2;
    int          bbsy_hold   = 0;
    bit          slave_en    = 1'b1;
    int          slave_delay = 5;
    logic [15:0] slave_data  = 16'h0000;

    int          t_npr, t_sack, t_bbsy, t_msyn, msyn_cycles, overlap;
    logic        got_ack;
    logic [3:0]  ack_v;
    logic [15:0] rdata_v;
    logic        nxm_v;
    logic [17:0] a_m;
    logic [1:0]  c_m;
    logic [15:0] d_m;
    logic        sack_m, bbsy_at_ack, msyn_at_ack;
    logic [17:0] a_at_ack;

    typedef struct {
        int          r;
        logic [17:0] addr;
        logic [1:0]  ctl;
        logic [15:0] wd;
        bit          resp;
        int          dly;
        logic [15:0] sdata;
        logic [15:0] exp_rdata;
        logic        exp_nxm;
        int          exp_msyn;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grant model: grants NPR after grant_delay cycles; optionally another master keeps BBSY.
    initial begin : grant_model
        int gcnt;
        int hcnt;
        gcnt = 0;
        hcnt = 0;
        npg_in_h  = 1'b0;
        bbsy_in_h = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (hcnt > 0) begin
                hcnt--;
                if (hcnt == 0) bbsy_in_h = 1'b0;
            end
            if (npg_in_h) begin
                if (sack_out_h || !npr_out_h) begin
                    npg_in_h = 1'b0;
                    gcnt = 0;
                    if (bbsy_hold > 0 && sack_out_h) begin
                        bbsy_in_h = 1'b1;
                        hcnt = bbsy_hold;
                    end
                end
            end else if (npr_out_h && !sack_out_h) begin
                gcnt++;
                if (gcnt >= grant_delay) npg_in_h = 1'b1;
            end
        end
    end

    // Slave model: answers MSYN with SSYN after slave_delay cycles, releases when MSYN drops.
    initial begin : slave_model
        int scnt;
        scnt = 0;
        ssyn_in_h = 1'b0;
        d_in_h    = 16'h0000;
        forever begin
            @(negedge CLOCK);
            if (!msyn_out_h) begin
                ssyn_in_h = 1'b0;
                d_in_h    = 16'h0000;
                scnt      = 0;
            end else if (slave_en && !ssyn_in_h) begin
                scnt++;
                if (scnt >= slave_delay) begin
                    ssyn_in_h = 1'b1;
                    d_in_h    = slave_data;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
    endtask

    // One request from requester r, observed until its ack or the cycle budget runs out.
    task automatic do_xfer(input int r, input logic [17:0] addr, input logic [1:0] ctl, input logic [15:0] wd);
        int cyc;
        t_npr = -1; t_sack = -1; t_bbsy = -1; t_msyn = -1;
        msyn_cycles = 0; overlap = 0; got_ack = 1'b0;
        ack_v = 4'h0; rdata_v = 16'h0000; nxm_v = 1'b0;
        a_m = 18'h0; c_m = 2'b00; d_m = 16'h0; sack_m = 1'b1;
        bbsy_at_ack = 1'b1; msyn_at_ack = 1'b1; a_at_ack = 18'h3ffff;
        req_addr[r*18 +: 18] = addr;
        req_ctl[r*2 +: 2]    = ctl;
        req_wdata[r*16 +: 16] = wd;
        req[r] = 1'b1;
        for (cyc = 1; cyc <= 3000 && !got_ack; cyc++) begin
            @(posedge CLOCK);
            #1;
            if (npr_out_h && t_npr < 0) t_npr = cyc;
            if (sack_out_h && t_sack < 0) t_sack = cyc;
            if (bbsy_out_h && t_bbsy < 0) t_bbsy = cyc;
            if (msyn_out_h) begin
                msyn_cycles++;
                if (t_msyn < 0) begin
                    t_msyn = cyc; a_m = a_out_h; c_m = c_out_h; d_m = d_out_h; sack_m = sack_out_h;
                end
            end
            if (bbsy_out_h && bbsy_in_h) overlap++;
            if (!bbsy_out_h && a_out_h != 18'h0) overlap++;
            if (ack != 4'h0) begin
                got_ack = 1'b1; ack_v = ack; rdata_v = rdata; nxm_v = nxm;
                bbsy_at_ack = bbsy_out_h; msyn_at_ack = msyn_out_h; a_at_ack = a_out_h;
                req = '0;
            end
        end
        req = '0;
    endtask

    logic [3:0]  exp_ack;
    logic [3:0]  ack_seq[5];
    logic [3:0]  exp_seq[5];
    int          tenure_at[6];
    int          exp_ten[6];
    int          n, tenures, addr_err, early_ack;
    logic        bbsy_prev, msyn_prev;

    initial begin
        RESET = 1'b1; init_in_h = 1'b0; req = '0;
        req_addr = '0; req_ctl = '0; req_wdata = '0;

        vecs[0] = '{2, 18'o001000, 2'b00, 16'h0000, 1'b1, 5, 16'o123456, 16'o123456, 1'b0, 5};
        vecs[1] = '{0, 18'o777776, 2'b10, 16'hA5A5, 1'b1, 3, 16'h1234, 16'h0000, 1'b0, 3};
        vecs[2] = '{3, 18'o000001, 2'b11, 16'hBE00, 1'b1, 1, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[3] = '{1, 18'o760000, 2'b10, 16'h0042, 1'b0, 5, 16'h0000, 16'h0000, 1'b1, TIMEOUT};
        vecs[4] = '{1, 18'o000100, 2'b00, 16'h0000, 1'b1, 2, 16'h0F0F, 16'h0F0F, 1'b0, 2};
        vecs[5] = '{0, 18'o777777, 2'b00, 16'h0000, 1'b1, 8, 16'hFFFF, 16'hFFFF, 1'b0, 8};

        do_reset();
        chk("reset_ack", {28'h0, ack}, 32'h0);
        chk("reset_busctl", {28'h0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 32'h0);
        chk("reset_addr", {14'h0, a_out_h}, 32'h0);
        chk("reset_data", {nxm, c_out_h, d_out_h, rdata}, 32'h0);
        RESET = 1'b0;

        for (int i = 0; i < 6; i++) begin
            slave_en = vecs[i].resp; slave_delay = vecs[i].dly; slave_data = vecs[i].sdata;
            do_xfer(vecs[i].r, vecs[i].addr, vecs[i].ctl, vecs[i].wd);
            exp_ack = 4'b0001 << vecs[i].r;
            chk($sformatf("v%0d_ack", i), {28'h0, ack_v}, {28'h0, exp_ack});
            chk($sformatf("v%0d_rdata", i), {16'h0, rdata_v}, {16'h0, vecs[i].exp_rdata});
            chk($sformatf("v%0d_nxm", i), {31'h0, nxm_v}, {31'h0, vecs[i].exp_nxm});
            chk($sformatf("v%0d_msyn_len", i), msyn_cycles, vecs[i].exp_msyn);
            chk($sformatf("v%0d_deskew", i), t_msyn - t_bbsy, DESKEW);
            chk($sformatf("v%0d_order", i),
                {31'h0, (t_npr > 0 && t_npr < t_sack && t_sack < t_bbsy && t_bbsy < t_msyn)}, 32'h1);
            chk($sformatf("v%0d_addr", i), {14'h0, a_m}, {14'h0, vecs[i].addr});
            chk($sformatf("v%0d_ctl", i), {30'h0, c_m}, {30'h0, vecs[i].ctl});
            chk($sformatf("v%0d_wdata", i), {16'h0, d_m},
                {16'h0, (vecs[i].ctl[1] ? vecs[i].wd : 16'h0000)});
            chk($sformatf("v%0d_sack_at_msyn", i), {31'h0, sack_m}, 32'h0);
            chk($sformatf("v%0d_released", i), {12'h0, bbsy_at_ack, msyn_at_ack, a_at_ack}, 32'h0);
            chk($sformatf("v%0d_overlap", i), overlap, 0);
            repeat (2) @(posedge CLOCK);
            #1;
        end

        // All four requesters held: round-robin from a freshly reset pointer.
        do_reset();
        RESET = 1'b0;
        slave_en = 1'b1; slave_delay = 1; slave_data = 16'h7777;
        for (int r = 0; r < NREQ; r++) begin
            req_addr[r*18 +: 18] = 18'o010000 + 18'(2 * r);
            req_ctl[r*2 +: 2] = 2'b00;
        end
`ifdef NPR_ARBITER_BURST_EN
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        ack_seq = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        n = 0;
        req = 4'b1111;
        for (int c = 0; c < 1000 && n < 5; c++) begin
            @(posedge CLOCK);
            #1;
            if (ack != 4'h0) begin
                ack_seq[n] = ack;
                n++;
            end
        end
        req = '0;
        for (int k = 0; k < 5; k++) chk($sformatf("rr_ack%0d", k), {28'h0, ack_seq[k]}, {28'h0, exp_seq[k]});
        repeat (30) @(posedge CLOCK);
        #1;

        // INIT pulsed while waiting for SSYN: abort without ack, then the request is re-served.
        slave_en = 1'b0; slave_delay = 2; slave_data = 16'o070707;
        req_addr[2*18 +: 18] = 18'o004000; req_ctl[2*2 +: 2] = 2'b00;
        req[2] = 1'b1;
        early_ack = 0;
        for (int c = 0; c < 200 && !msyn_out_h; c++) begin
            @(posedge CLOCK);
            #1;
            if (ack != 4'h0) early_ack++;
        end
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        init_in_h = 1'b1;
        @(posedge CLOCK);
        #1;
        chk("init_busctl", {28'h0, npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h}, 32'h0);
        chk("init_bus_ad", {a_out_h, c_out_h, d_out_h}, 36'h0);
        if (ack != 4'h0) early_ack++;
        @(negedge CLOCK);
        init_in_h = 1'b0;
        slave_en = 1'b1;
        got_ack = 1'b0; ack_v = 4'h0; rdata_v = 16'h0;
        for (int c = 0; c < 300 && !got_ack; c++) begin
            @(posedge CLOCK);
            #1;
            if (ack != 4'h0) begin
                got_ack = 1'b1; ack_v = ack; rdata_v = rdata; req = '0;
            end
        end
        req = '0;
        chk("init_no_ack", early_ack, 0);
        chk("init_reserve_ack", {28'h0, ack_v}, 32'h4);
        chk("init_reserve_rdata", {16'h0, rdata_v}, {16'h0, 16'o070707});
        repeat (3) @(posedge CLOCK);
        #1;

        // Another master keeps BBSY for 50 cycles after the grant.
        bbsy_hold = 50; slave_en = 1'b1; slave_delay = 3; slave_data = 16'h5A5A;
        do_xfer(0, 18'o000200, 2'b00, 16'h0000);
        bbsy_hold = 0;
        chk("bbsy_hold_ack", {28'h0, ack_v}, 32'h1);
        chk("bbsy_hold_rdata", {16'h0, rdata_v}, 32'h5A5A);
        chk("bbsy_hold_overlap", overlap, 0);
        chk("bbsy_hold_wait", {31'h0, ((t_bbsy - t_sack) >= 50)}, 32'h1);
        repeat (3) @(posedge CLOCK);
        #1;

        // Requester 1 posts six back-to-back DATOs.
`ifdef NPR_ARBITER_BURST_EN
        exp_ten = '{1, 1, 1, 1, 2, 2};
`else
        exp_ten = '{1, 2, 3, 4, 5, 6};
`endif
        slave_en = 1'b1; slave_delay = 2;
        n = 0; tenures = 0; addr_err = 0;
        bbsy_prev = 1'b0; msyn_prev = 1'b0;
        req_addr[1*18 +: 18] = 18'o002000; req_ctl[1*2 +: 2] = 2'b10; req_wdata[1*16 +: 16] = 16'h1000;
        req[1] = 1'b1;
        for (int c = 0; c < 2000 && n < 6; c++) begin
            @(posedge CLOCK);
            #1;
            if (bbsy_out_h && !bbsy_prev) tenures++;
            if (msyn_out_h && !msyn_prev) begin
                if (a_out_h != 18'o002000 + 18'(2 * n)) addr_err++;
                if (d_out_h != 16'h1000 + 16'(n)) addr_err++;
            end
            bbsy_prev = bbsy_out_h;
            msyn_prev = msyn_out_h;
            if (ack != 4'h0) begin
                if (ack != 4'b0010) addr_err++;
                tenure_at[n] = tenures;
                n++;
                req_addr[1*18 +: 18] = 18'o002000 + 18'(2 * n);
                req_wdata[1*16 +: 16] = 16'h1000 + 16'(n);
                if (n == 6) req = '0;
            end
        end
        req = '0;
        chk("burst_count", n, 6);
        chk("burst_operands", addr_err, 0);
        for (int k = 0; k < 6; k++) chk($sformatf("burst_tenure%0d", k), (k < n) ? tenure_at[k] : -1, exp_ten[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
